// File: rtl/mhp_pkg.sv
// mhp_pkg: shared MHP frame constants, receiver state encoding and header byte offsets
package mhp_pkg;
  localparam int MHP_HDR_LEN     = 7;
  localparam int MHP_MAX_PAYLOAD = 42;
  localparam int MHP_SCS_LEN     = 2;
  localparam int OFF_DST_LO      = 0;
  localparam int OFF_DST_HI      = 1;
  localparam int OFF_SRC_LO      = 2;
  localparam int OFF_SRC_HI      = 3;
  localparam int OFF_SIZE_HI     = 4;
  localparam int OFF_SIZE_LO     = 5;
  localparam int OFF_DIR_TYPE    = 6;
  typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_SCS, ST_DONE} mhp_state_e;
  function automatic logic [5:0] mhp_clamp(input logic [5:0] n);
    return (n > 6'(MHP_MAX_PAYLOAD)) ? 6'(MHP_MAX_PAYLOAD) : n;
  endfunction
endpackage

// File: rtl/frame_disassembly_if.sv
// frame_disassembly_if: received byte stream in, decoded frame out
interface frame_disassembly_if;
  import mhp_pkg::*;
  logic [7:0]                   i_rdata;
  logic                         i_rvalid;
  logic [5:0]                   i_payload_size;
  logic [15:0]                  o_dst;
  logic [15:0]                  o_src;
  logic [15:0]                  o_size;
  logic                         o_dir;
  logic [6:0]                   o_type;
  logic [8*MHP_MAX_PAYLOAD-1:0] o_payload;
  logic [15:0]                  o_scs;
  logic                         o_scs_ok;
  logic                         o_done;
  logic                         o_err;
  modport master (
    output i_rdata, i_rvalid, i_payload_size,
    input  o_dst, o_src, o_size, o_dir, o_type, o_payload, o_scs, o_scs_ok, o_done, o_err
  );
  modport slave (
    input  i_rdata, i_rvalid, i_payload_size,
    output o_dst, o_src, o_size, o_dir, o_type, o_payload, o_scs, o_scs_ok, o_done, o_err
  );
endinterface

// File: rtl/mhp_checksum.sv
// mhp_checksum: 16-bit additive byte accumulator; clear together with add loads the byte
module mhp_checksum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [7:0]  data_i,
  output logic [15:0] value_o
);
  logic [15:0] acc_q;
  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else if (clr_i) acc_q <= add_i ? {8'd0, data_i} : '0;
    else if (add_i) acc_q <= acc_q + {8'd0, data_i};
  end
  assign value_o = acc_q;
endmodule

// File: rtl/frame_disassembly.sv
// frame_disassembly: parses an MHP byte stream into header, payload and checksum fields
module frame_disassembly
  import mhp_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  frame_disassembly_if.slave bus
);
  mhp_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d, n_q, hdr_idx;
  logic v, busy, last_scs, sum_clr, sum_add, ok_q, err_q;
  logic [7:0] d, dt_sh_q, scs_hi_q, dt_q;
  logic [15:0] sum, scs_rx, dst_sh_q, src_sh_q, size_sh_q, dst_q, src_q, size_q, scs_q;
  logic [8*MHP_MAX_PAYLOAD-1:0] pay_sh_q, pay_q;
  assign v        = bus.i_rvalid;
  assign d        = bus.i_rdata;
  assign hdr_idx  = cnt_q + 6'd1;
  assign busy     = state_q inside {ST_HEADER, ST_PAYLOAD, ST_SCS};
  assign last_scs = state_q == ST_SCS && v && cnt_q == 6'(MHP_SCS_LEN-1);
  assign sum_clr  = state_q == ST_IDLE && v;
  assign sum_add  = v && state_q inside {ST_IDLE, ST_HEADER, ST_PAYLOAD};
  assign scs_rx   = {scs_hi_q, d};
  mhp_checksum u_sum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (sum_clr),
    .add_i   (sum_add),
    .data_i  (d),
    .value_o (sum)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // b0 is consumed in IDLE, so header byte index is the counter plus one
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = v ? ST_HEADER : ST_IDLE;
      ST_HEADER:  state_d = !v ? ST_IDLE : hdr_idx != 6'(MHP_HDR_LEN-1) ? ST_HEADER :
                            n_q == '0 ? ST_SCS : ST_PAYLOAD;
      ST_PAYLOAD: state_d = !v ? ST_IDLE : cnt_q == n_q - 6'd1 ? ST_SCS : ST_PAYLOAD;
      ST_SCS:     state_d = !v ? ST_IDLE : last_scs ? ST_DONE : ST_SCS;
      default:    state_d = ST_IDLE;
    endcase
    cnt_d = state_d != state_q ? '0 : cnt_q + 6'(v);
  end
  always_comb begin
    bus.o_done    = state_q == ST_DONE;
    bus.o_err     = err_q;
    bus.o_dst     = dst_q;
    bus.o_src     = src_q;
    bus.o_size    = size_q;
    bus.o_dir     = dt_q[7];
    bus.o_type    = dt_q[6:0];
    bus.o_payload = pay_q;
    bus.o_scs     = scs_q;
    bus.o_scs_ok  = ok_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q       <= '0;
      dst_sh_q  <= '0;
      src_sh_q  <= '0;
      size_sh_q <= '0;
      dt_sh_q   <= '0;
      scs_hi_q  <= '0;
      pay_sh_q  <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      size_q    <= '0;
      dt_q      <= '0;
      pay_q     <= '0;
      scs_q     <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= busy && !v;
      if (state_q == ST_IDLE && v) begin
        n_q            <= mhp_clamp(bus.i_payload_size);
        dst_sh_q[7:0]  <= d;
        pay_sh_q       <= '0;
      end
      if (state_q == ST_HEADER && v) begin
        if (hdr_idx == 6'(OFF_DST_HI))   dst_sh_q[15:8]  <= d;
        if (hdr_idx == 6'(OFF_SRC_LO))   src_sh_q[7:0]   <= d;
        if (hdr_idx == 6'(OFF_SRC_HI))   src_sh_q[15:8]  <= d;
        if (hdr_idx == 6'(OFF_SIZE_HI))  size_sh_q[15:8] <= d;
        if (hdr_idx == 6'(OFF_SIZE_LO))  size_sh_q[7:0]  <= d;
        if (hdr_idx == 6'(OFF_DIR_TYPE)) dt_sh_q         <= d;
      end
      if (state_q == ST_PAYLOAD && v)
        for (int k = 0; k < MHP_MAX_PAYLOAD; k++)
          if (cnt_q == 6'(k)) pay_sh_q[8*k +: 8] <= d;
      if (state_q == ST_SCS && v && cnt_q == '0) scs_hi_q <= d;
      // frame outputs change only when a complete frame lands
      if (last_scs) begin
        dst_q  <= dst_sh_q;
        src_q  <= src_sh_q;
        size_q <= size_sh_q;
        dt_q   <= dt_sh_q;
        pay_q  <= pay_sh_q;
        scs_q  <= scs_rx;
        ok_q   <= sum == scs_rx;
      end
    end
  end
endmodule

// File: tb/tb_frame_disassembly.sv
// tb_frame_disassembly: table, corner-case and random frames against a field-level reference model
module tb_frame_disassembly;
  import mhp_pkg::*;
  typedef struct packed {
    logic [5:0]   n;
    logic [15:0]  dst, src, size;
    logic [7:0]   dt;
    logic [335:0] pay;
    logic         corrupt;
  } frame_t;
  typedef struct packed {
    logic [15:0]  dst, src, size;
    logic         dir;
    logic [6:0]   typ;
    logic [335:0] pay;
    logic [15:0]  scs;
    logic         ok;
  } exp_t;
  typedef struct packed {
    frame_t f;
    logic   exp_ok;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0, done_cnt = 0, err_cnt = 0, d0, e0, cut;
  logic [7:0] wire_q[$];
  vec_t vecs[6];
  exp_t e, e2, held, zero_e;
  frame_t f, f2;

  always #5 clk = ~clk;
  frame_disassembly_if bus();
  frame_disassembly dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always @(posedge clk) begin
    #1;
    if (bus.o_done) done_cnt++;
    if (bus.o_err) err_cnt++;
  end

  function automatic frame_t mk(logic [5:0] n, logic [15:0] dst, logic [15:0] src,
                                logic [15:0] size, logic [7:0] dt, logic [7:0] base, logic corrupt);
    frame_t r;
    r.n = n; r.dst = dst; r.src = src; r.size = size; r.dt = dt; r.corrupt = corrupt;
    for (int k = 0; k < 42; k++) r.pay[8*k +: 8] = base + 8'(k);
    return r;
  endfunction

  // wire image and expected decode straight from the frame layout rules
  function automatic exp_t model(frame_t fr);
    exp_t x;
    int n;
    logic [15:0] s;
    n = fr.n > 6'd42 ? 42 : int'(fr.n);
    s = '0;
    x = '0;
    wire_q.delete();
    wire_q.push_back(fr.dst[7:0]);
    wire_q.push_back(fr.dst[15:8]);
    wire_q.push_back(fr.src[7:0]);
    wire_q.push_back(fr.src[15:8]);
    wire_q.push_back(fr.size[15:8]);
    wire_q.push_back(fr.size[7:0]);
    wire_q.push_back(fr.dt);
    for (int k = 0; k < n; k++) begin
      wire_q.push_back(fr.pay[8*k +: 8]);
      x.pay[8*k +: 8] = fr.pay[8*k +: 8];
    end
    foreach (wire_q[i]) s = s + 16'(wire_q[i]);
    x.scs = s ^ 16'(fr.corrupt);
    wire_q.push_back(x.scs[15:8]);
    wire_q.push_back(x.scs[7:0]);
    x.dst = fr.dst; x.src = fr.src; x.size = fr.size;
    x.dir = fr.dt[7]; x.typ = fr.dt[6:0]; x.ok = !fr.corrupt;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [335:0] a, input logic [335:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, x);
    end
  endtask

  task automatic chk_frame(input string nm, input exp_t x);
    chk({nm, ".dst"},  336'(bus.o_dst),    336'(x.dst));
    chk({nm, ".src"},  336'(bus.o_src),    336'(x.src));
    chk({nm, ".size"}, 336'(bus.o_size),   336'(x.size));
    chk({nm, ".dir"},  336'(bus.o_dir),    336'(x.dir));
    chk({nm, ".type"}, 336'(bus.o_type),   336'(x.typ));
    chk({nm, ".pay"},  bus.o_payload,      x.pay);
    chk({nm, ".scs"},  336'(bus.o_scs),    336'(x.scs));
    chk({nm, ".ok"},   336'(bus.o_scs_ok), 336'(x.ok));
  endtask

  task automatic drive(input logic [7:0] b, input logic [5:0] n);
    @(negedge clk);
    bus.i_rvalid = 1'b1;
    bus.i_rdata = b;
    bus.i_payload_size = n;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.i_rvalid = 1'b0;
    bus.i_rdata = 8'($urandom);
    bus.i_payload_size = 6'($urandom);
  endtask

  // size input is only meaningful on b0; later bytes carry noise on it
  task automatic send(input frame_t fr, input int nbytes);
    for (int i = 0; i < nbytes; i++) drive(wire_q[i], i == 0 ? fr.n : 6'($urandom));
    idle();
  endtask

  task automatic full(input string nm, input frame_t fr, output exp_t x);
    x = model(fr);
    send(fr, wire_q.size());
    chk({nm, ".done"}, 336'(bus.o_done), 336'(1));
    chk({nm, ".err"},  336'(bus.o_err),  336'(0));
    chk_frame(nm, x);
  endtask

  initial begin
    bus.i_rvalid = 1'b0;
    bus.i_rdata = '0;
    bus.i_payload_size = '0;
    zero_e = '0;
    repeat (3) @(negedge clk);
    chk_frame("rst", zero_e);
    chk("rst.done", 336'(bus.o_done), 336'(0));
    chk("rst.err",  336'(bus.o_err),  336'(0));
    rst_n = 1'b1;

    vecs[0].f = mk(6'd42, 16'h1234, 16'hABCD, 16'h002A, 8'h85, 8'h00, 1'b0); vecs[0].exp_ok = 1'b1;
    vecs[1].f = mk(6'd0,  16'hBEEF, 16'h0102, 16'h0000, 8'h7F, 8'h50, 1'b0); vecs[1].exp_ok = 1'b1;
    vecs[2].f = mk(6'd42, 16'h1234, 16'hABCD, 16'h002A, 8'h85, 8'h00, 1'b1); vecs[2].exp_ok = 1'b0;
    vecs[3].f = mk(6'd50, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFF, 8'hC0, 1'b0); vecs[3].exp_ok = 1'b1;
    vecs[4].f = mk(6'd1,  16'h0001, 16'h8000, 16'h0001, 8'h01, 8'hA5, 1'b0); vecs[4].exp_ok = 1'b1;
    vecs[5].f = mk(6'd63, 16'h5A5A, 16'hA5A5, 16'h0040, 8'h80, 8'h33, 1'b1); vecs[5].exp_ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt; e0 = err_cnt;
      full($sformatf("vec%0d", i), vecs[i].f, e);
      chk($sformatf("vec%0d.okflag", i), 336'(bus.o_scs_ok), 336'(vecs[i].exp_ok));
      @(negedge clk);
      chk($sformatf("vec%0d.done_pulse", i), 336'(bus.o_done), 336'(0));
      chk($sformatf("vec%0d.ndone", i), 336'(done_cnt - d0), 336'(1));
      chk($sformatf("vec%0d.nerr", i),  336'(err_cnt - e0),  336'(0));
    end
    held = e;

    d0 = done_cnt; e0 = err_cnt;
    f = mk(6'd10, 16'h1111, 16'h2222, 16'h000A, 8'h03, 8'h90, 1'b0);
    e = model(f);
    send(f, 13);
    @(negedge clk);
    chk("trunc.err", 336'(bus.o_err), 336'(1));
    @(negedge clk);
    chk("trunc.err_pulse", 336'(bus.o_err), 336'(0));
    chk_frame("trunc", held);
    chk("trunc.ndone", 336'(done_cnt - d0), 336'(0));
    chk("trunc.nerr",  336'(err_cnt - e0),  336'(1));

    d0 = done_cnt; e0 = err_cnt;
    f = mk(6'd20, 16'h7777, 16'h8888, 16'h0014, 8'h11, 8'h40, 1'b0);
    e = model(f);
    for (int i = 0; i < 20; i++) drive(wire_q[i], i == 0 ? f.n : 6'($urandom));
    @(negedge clk);
    rst_n = 1'b0; bus.i_rvalid = 1'b1; bus.i_rdata = wire_q[20];
    @(negedge clk);
    rst_n = 1'b1; bus.i_rvalid = 1'b0;
    chk_frame("midrst", zero_e);
    f = mk(6'd4, 16'h4321, 16'h8765, 16'h0004, 8'h92, 8'hE0, 1'b0);
    full("post_rst", f, e);
    @(negedge clk);
    chk("midrst.ndone", 336'(done_cnt - d0), 336'(1));
    chk("midrst.nerr",  336'(err_cnt - e0),  336'(0));

    d0 = done_cnt;
    f  = mk(6'd3, 16'hAAAA, 16'hBBBB, 16'h0003, 8'h21, 8'h10, 1'b0);
    f2 = mk(6'd5, 16'hCCCC, 16'hDDDD, 16'h0005, 8'hA2, 8'h70, 1'b0);
    full("b2b1", f, e);
    full("b2b2", f2, e2);
    chk("b2b.pay34", 336'(bus.o_payload[39:24]), 336'(16'h7473));
    @(negedge clk);
    chk("b2b.ndone", 336'(done_cnt - d0), 336'(2));
    held = e2;

    for (int r = 0; r < 60; r++) begin
      f.n = 6'($urandom); f.dst = 16'($urandom); f.src = 16'($urandom);
      f.size = 16'($urandom); f.dt = 8'($urandom); f.corrupt = $urandom_range(0, 3) == 0;
      for (int k = 0; k < 42; k++) f.pay[8*k +: 8] = 8'($urandom);
      e = model(f);
      if ($urandom_range(0, 4) == 0) begin
        d0 = done_cnt; e0 = err_cnt;
        cut = $urandom_range(1, wire_q.size() - 1);
        send(f, cut);
        repeat (2) @(negedge clk);
        chk_frame($sformatf("rnd%0d_trunc", r), held);
        chk($sformatf("rnd%0d.ndone", r), 336'(done_cnt - d0), 336'(0));
        chk($sformatf("rnd%0d.nerr", r),  336'(err_cnt - e0),  336'(1));
      end else begin
        full($sformatf("rnd%0d", r), f, e);
        held = e;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_disassembly.md
# frame_disassembly

Receive-side counterpart of the MHP frame transmitter. It accepts a byte stream (one byte per cycle while valid) from the link receiver and parses it into header fields, payload and checksum. It verifies a 16-bit additive checksum and presents the decoded frame with a one-cycle `done` pulse to the protocol logic.

## Interface
- `MHP_MAX_PAYLOAD`, 42: maximum payload bytes; the payload bus is 8×this wide.
- `MHP_HDR_LEN`, 7: header bytes (dst 2, src 2, size 2, dir/type 1).
- `clk  in  1`: single clock; all logic on the rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `i_rdata  in  8`: received byte.
- `i_rvalid  in  1`: `i_rdata` valid this cycle; it stays high for the whole frame.
- `i_payload_size  in  6`: payload length N for the next frame; sampled on the first byte; values >42 are clamped to 42.
- `o_dst  out  16`: destination address.
- `o_src  out  16`: source address.
- `o_size  out  16`: size field.
- `o_dir  out  1`: direction bit.
- `o_type  out  7`: frame type.
- `o_payload  out  336`: payload; byte k at [8k+7:8k]; bytes ≥N are zero.
- `o_scs  out  16`: checksum as received.
- `o_scs_ok  out  1`: computed checksum equals `o_scs`.
- `o_done  out  1`: one-cycle pulse; the frame outputs above are valid and updated.
- `o_err  out  1`: one-cycle pulse; the frame was truncated because `i_rvalid` dropped mid-frame.

## Operation
- Wire byte order, index b from 0:
  - b0 `dst[7:0]`, b1 `dst[15:8]`
  - b2 `src[7:0]`, b3 `src[15:8]`
  - b4 `size[15:8]`, b5 `size[7:0]`
  - b6 `{dir, type[6:0]}` (dir is bit 7)
  - b7..b(6+N) payload bytes 0..N-1
  - b(7+N) `scs[15:8]`, b(8+N) `scs[7:0]`
- Total frame length is N+9 bytes.
- Checksum: 16-bit sum, mod 2^16, of bytes b0..b(6+N), each zero-extended.
- States and transitions:
  - IDLE → HEADER on the first `i_rvalid`. That byte is consumed as b0, N is latched, the running sum is set to b0, and the shadow payload register is cleared.
  - HEADER → PAYLOAD after b6, or HEADER → SCS if N=0.
  - PAYLOAD → SCS after N bytes.
  - SCS → DONE after 2 bytes.
  - DONE → IDLE unconditionally.
- Byte counter: 6 bits, counts the bytes consumed in the current state and resets on every state change.
- Fields are assembled in shadow registers. The `o_*` frame outputs are copied from the shadows only on entry to DONE and hold until the next successful frame.
- `o_scs_ok` is registered on the same edge as the other outputs. It is the comparison of the final sum against the received scs.
- Truncation: `i_rvalid` low in HEADER, PAYLOAD or SCS:
  - pulse `o_err` the next cycle and return to IDLE;
  - `o_done` does not pulse and the `o_*` frame outputs keep their previous values.
- `i_rvalid` high in DONE is ignored; that byte is lost. The transmitter guarantees at least one idle cycle between frames.
- Reset values: all `o_*` are 0. `o_scs_ok` is 0, state is IDLE, shadows and counter are 0.
- Reset asserted mid-frame: the state goes to IDLE on the next edge and no `o_done`/`o_err` pulse follows.

## Timing
- Throughput: one byte per cycle and no backpressure; a ready signal does not exist.
- Latency: `o_done` and the updated outputs appear the cycle after the last scs byte is sampled.
- `o_done` is high for exactly one cycle.
- The earliest next frame's b0 is 2 cycles after the last scs byte: the DONE cycle, then IDLE.
- `o_err` is asserted the cycle after the first invalid cycle, for exactly one cycle.
- `i_payload_size` changes mid-frame have no effect.

## Structure
- The shared package `mhp_pkg` holds:
  - `MHP_HDR_LEN`, `MHP_MAX_PAYLOAD` and `MHP_SCS_LEN` (2);
  - the state encoding;
  - the byte-offset constants of the header fields.
- The transmitter migrates to the same package.
- One sub-module, `mhp_checksum`: a 16-bit accumulator with clear/add/value ports. It is reused by whatever block generates the transmitter's `i_scs`.
- The payload shadow is written by byte index (demux on the counter), not a 336-bit shift.

## Test plan
- Full frame: N=42, dst=0x1234, src=0xABCD, size=0x002A, dir=1, type=0x05, payload bytes 0x00..0x29, correct scs → single `o_done`; fields decode to those exact values; `o_scs_ok`=1; `o_err` never asserts.
- Empty payload: N=0, 9 bytes, correct scs → `o_done` the cycle after byte 8; `o_payload`=0; `o_scs_ok`=1.
- Bad checksum: the same as the full frame with the scs low byte XOR 0x01 → `o_done` pulses; `o_scs_ok`=0; `o_scs` shows the corrupted value.
- Truncation: N=10, `i_rvalid` dropped after byte 12 → `o_err` pulses once; no `o_done`; outputs still hold the previous frame.
- Reset mid-frame: `rst_n` low for 1 cycle at byte 20, then a fresh valid frame with N=4 → only the second frame produces `o_done`, with correct fields.
- Back-to-back: frames with N=3 and N=5 separated by exactly one idle cycle → two `o_done` pulses; the second overwrites all fields; payload bytes 3..4 of the second frame are not stale.
